// File: rtl/rgb_led_pwm.sv
// rtl/rgb_led_pwm.sv - per-channel PWM driver for the active-low RGB LED with double-buffered colour commands
// Optional ramp between colours: define RGB_LED_FADE_EN.
module rgb_led_pwm #(
  parameter int PRESCALE = 12,
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [PWM_BITS-1:0] i_red,
  input  logic [PWM_BITS-1:0] i_green,
  input  logic [PWM_BITS-1:0] i_blue,
  output logic                o_period_start,
  output logic                o_settled,
  output logic                led0_r,
  output logic                led0_g,
  output logic                led0_b
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]       PLAST = PW'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] CLAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic [PW-1:0]                  pcnt;
  logic [PWM_BITS-1:0]            cnt;
  logic [PWM_BITS-1:0]            cnt_nxt;
  logic                           tick;
  logic                           boundary;
  logic                           accept;
  logic                           pending;
  // channel index: 2 = red, 1 = green, 0 = blue
  logic [2:0][PWM_BITS-1:0]       shadow;
  logic [2:0][PWM_BITS-1:0]       target;
  logic [2:0][PWM_BITS-1:0]       active;
  logic [2:0][PWM_BITS-1:0]       active_nxt;

  assign tick     = (pcnt == PLAST);
  assign boundary = tick && (cnt == CLAST);
  assign accept   = i_valid && !pending;
  assign cnt_nxt  = !tick ? cnt : ((cnt == CLAST) ? '0 : cnt + 1'b1);

  always_comb begin
    active_nxt = active;
    if (boundary) begin
`ifdef RGB_LED_FADE_EN
      // ramp toward the value target is about to take, one step per period
      for (int c = 0; c < 3; c++) begin
        if (active[c] < shadow[c])
          active_nxt[c] = active[c] + 1'b1;
        else if (active[c] > shadow[c])
          active_nxt[c] = active[c] - 1'b1;
      end
`else
      active_nxt = shadow;
`endif
    end
  end

  // LEDs compare the values that will hold next cycle, so the registered
  // output lines up with cnt/active of the cycle it is shown in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt           <= '0;
      cnt            <= '0;
      shadow         <= '0;
      target         <= '0;
      active         <= '0;
      pending        <= 1'b0;
      o_period_start <= 1'b0;
      led0_r         <= 1'b1;
      led0_g         <= 1'b1;
      led0_b         <= 1'b1;
    end else begin
      pcnt   <= tick ? '0 : pcnt + 1'b1;
      cnt    <= cnt_nxt;
      active <= active_nxt;
      if (boundary)
        target <= shadow;
      if (accept) begin
        shadow  <= {i_red, i_green, i_blue};
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
      o_period_start <= boundary;
      led0_r         <= !(cnt_nxt < active_nxt[2]);
      led0_g         <= !(cnt_nxt < active_nxt[1]);
      led0_b         <= !(cnt_nxt < active_nxt[0]);
    end
  end

  assign o_ready   = !pending;
  assign o_settled = !pending && (active == target);

endmodule
